// File: rtl/riscv_pkg.sv
// Shared definitions for the microprogrammed control sequencer.
// Holds the data width, the major opcode constants that the dispatch ROMs
// decode, the fetch state enumeration and a small alignment helper.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    // Instruction addresses must be word aligned.
    function automatic logic is_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read bus.
//   mem_req   : read request, held until acknowledged
//   mem_addr  : word address, stable while mem_req is high
//   mem_ack   : read data valid this cycle
//   mem_err   : bus error, only meaningful together with mem_ack
//   mem_rdata : returned instruction word
// The fetch unit uses the master modport, the memory model the slave one.
interface instr_fetch_unit_if;
    import riscv_pkg::*;

    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_ack;
    logic            mem_err;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_err,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_err,
        output mem_rdata
    );

endinterface

// File: rtl/fetch_timeout.sv
// Wait-cycle counter for an outstanding instruction fetch.
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : synchronous clear, takes priority over en
//   en         : count one cycle spent waiting
//   tc         : the current cycle is the LIMIT-th waiting cycle
module fetch_timeout #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count;

    // count holds the number of waiting cycles already completed, so the
    // cycle being spent now is number count+1; it saturates at the last one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC and the instruction register.
//   clk, rst_n      : clock and asynchronous active-low reset
//   fetch_req       : start a fetch at the current PC
//   pc_load         : redirect the PC to pc_target
//   pc_target       : redirect address (must be word aligned)
//   mem             : instruction memory read bus (master side)
//   instr           : IR contents; op/rd/rs1/rs2/funct3/funct7 are slices
//   pc, old_pc      : next fetch address / address of the word in IR
//   ir_valid        : single-cycle flag, IR was just loaded
//   busy            : fetch in flight
//   fault           : sticky fetch fault, cleared only by reset
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              TIMEOUT  = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_req,
    input  logic            pc_load,
    input  logic [XLEN-1:0] pc_target,
    instr_fetch_unit_if.master mem,
    output logic [XLEN-1:0] instr,
    output logic [6:0]      op,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] old_pc,
    output logic            ir_valid,
    output logic            busy,
    output logic            fault
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_REQ   = REQ;
    localparam logic [1:0] S_FAULT = FAULT;

    logic [1:0]      state;
    logic            pend_valid;
    logic [XLEN-1:0] pend_target;
    logic            timeout_hit;
    logic            bad_target;
    logic            to_fault;

    generate
        if (TIMEOUT > 0) begin : g_timeout
            fetch_timeout #(.LIMIT(TIMEOUT)) u_timeout (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (state != S_REQ),
                .en    (state == S_REQ),
                .tc    (timeout_hit)
            );
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    assign bad_target = pc_load && !is_aligned(pc_target);

    // A misaligned redirect, an acknowledged bus error or running out of
    // wait cycles all end in the sticky fault state. An ack arriving on the
    // last permitted wait cycle still wins over the timeout.
    always_comb begin
        to_fault = 1'b0;
        if (state == S_IDLE) begin
            to_fault = bad_target;
        end else if (state == S_REQ) begin
            to_fault = bad_target
                    || (mem.mem_ack && mem.mem_err)
                    || (!mem.mem_ack && timeout_hit);
        end
    end

    // Main sequencer. In the fault state the IR is forced to zero so the
    // dispatch ROMs see opcode 0 and fall into their default entry. A
    // redirect seen while waiting is kept pending and replaces PC+4 when
    // the word arrives; the latest redirect always wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            old_pc       <= RESET_PC;
            mem.mem_addr <= RESET_PC;
            mem.mem_req  <= 1'b0;
            instr        <= '0;
            ir_valid     <= 1'b0;
            busy         <= 1'b0;
            fault        <= 1'b0;
            pend_valid   <= 1'b0;
            pend_target  <= '0;
        end else if (to_fault || (state == S_FAULT)) begin
            state       <= S_FAULT;
            mem.mem_req <= 1'b0;
            busy        <= 1'b0;
            fault       <= 1'b1;
            ir_valid    <= 1'b0;
            instr       <= '0;
            pend_valid  <= 1'b0;
        end else if (state == S_IDLE) begin
            mem.mem_addr <= pc_load ? pc_target : pc;
            ir_valid     <= 1'b0;
            pend_valid   <= 1'b0;
            if (pc_load) begin
                pc <= pc_target;
            end
            if (fetch_req) begin
                state       <= S_REQ;
                mem.mem_req <= 1'b1;
                busy        <= 1'b1;
            end
        end else if (state == S_REQ) begin
            if (mem.mem_ack) begin
                state       <= S_IDLE;
                mem.mem_req <= 1'b0;
                busy        <= 1'b0;
                instr       <= mem.mem_rdata;
                old_pc      <= mem.mem_addr;
                ir_valid    <= 1'b1;
                pend_valid  <= 1'b0;
                if (pc_load) begin
                    pc <= pc_target;
                end else if (pend_valid) begin
                    pc <= pend_target;
                end else begin
                    pc <= mem.mem_addr + 32'd4;
                end
            end else if (pc_load) begin
                pend_valid  <= 1'b1;
                pend_target <= pc_target;
            end
        end else begin
            state <= S_IDLE;
        end
    end

    assign op     = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit.
// Unit A uses default parameters, unit B has RESET_PC=0x1000 and TIMEOUT=4.
// Expected values come from a transaction-level model: each fetch reads the
// architectural PC (or the redirect given with it), and on completion the
// PC becomes the last redirect seen during the wait or the fetch address+4.
module tb_instr_fetch_unit;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        a_fetch_req, a_pc_load;
    logic [31:0] a_pc_target;
    logic [31:0] a_instr, a_pc, a_old_pc;
    logic [6:0]  a_op, a_funct7;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [2:0]  a_funct3;
    logic        a_ir_valid, a_busy, a_fault;
    instr_fetch_unit_if a_bus ();

    logic        b_fetch_req, b_pc_load;
    logic [31:0] b_pc_target;
    logic [31:0] b_instr, b_pc, b_old_pc;
    logic [6:0]  b_op, b_funct7;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [2:0]  b_funct3;
    logic        b_ir_valid, b_busy, b_fault;
    instr_fetch_unit_if b_bus ();

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(255)) dut_a (
        .clk(clk), .rst_n(rst_n), .fetch_req(a_fetch_req), .pc_load(a_pc_load),
        .pc_target(a_pc_target), .mem(a_bus), .instr(a_instr), .op(a_op),
        .rd(a_rd), .rs1(a_rs1), .rs2(a_rs2), .funct3(a_funct3), .funct7(a_funct7),
        .pc(a_pc), .old_pc(a_old_pc), .ir_valid(a_ir_valid), .busy(a_busy),
        .fault(a_fault)
    );

    instr_fetch_unit #(.RESET_PC(32'h0000_1000), .TIMEOUT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .fetch_req(b_fetch_req), .pc_load(b_pc_load),
        .pc_target(b_pc_target), .mem(b_bus), .instr(b_instr), .op(b_op),
        .rd(b_rd), .rs1(b_rs1), .rs2(b_rs2), .funct3(b_funct3), .funct7(b_funct7),
        .pc(b_pc), .old_pc(b_old_pc), .ir_valid(b_ir_valid), .busy(b_busy),
        .fault(b_fault)
    );

    // Architectural PC of unit A as the model sees it.
    logic [31:0] m_pc;

    task automatic check_output(input string tag, input logic [31:0] got,
                                input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One complete fetch on unit A, starting at a negedge with A idle.
    // noise bit0: random fetch_req pulses while waiting
    // noise bit1: random aligned redirects while waiting
    task automatic apply_stimulus(input logic [31:0] rdata, input int delay,
                                  input bit with_load, input logic [31:0] load_tgt,
                                  input bit mid_load, input logic [31:0] mid_tgt,
                                  input int noise);
        logic [31:0] addr;
        logic [31:0] next_pc;
        logic [31:0] t;
        addr    = with_load ? load_tgt : m_pc;
        next_pc = addr + 32'd4;
        a_fetch_req = 1'b1;
        a_pc_load   = with_load;
        a_pc_target = load_tgt;
        @(negedge clk);
        a_fetch_req = 1'b0;
        a_pc_load   = 1'b0;
        for (int w = 0; w <= delay; w++) begin
            check_output("mem_req_wait", 32'(a_bus.mem_req), 32'd1);
            check_output("mem_addr_wait", a_bus.mem_addr, addr);
            check_output("busy_wait", 32'(a_busy), 32'd1);
            a_pc_load = 1'b0;
            if (w == delay) begin
                a_bus.mem_ack   = 1'b1;
                a_bus.mem_rdata = rdata;
                a_fetch_req     = 1'b0;
            end else begin
                a_bus.mem_ack   = 1'b0;
                a_bus.mem_rdata = $urandom();
                a_fetch_req     = (noise[0]) ? 1'($urandom_range(0, 1)) : 1'b0;
                if (mid_load && w == 0) begin
                    a_pc_load   = 1'b1;
                    a_pc_target = mid_tgt;
                    next_pc     = mid_tgt;
                end else if (noise[1] && $urandom_range(0, 2) == 0) begin
                    t           = $urandom() & 32'hFFFF_FFFC;
                    a_pc_load   = 1'b1;
                    a_pc_target = t;
                    next_pc     = t;
                end
            end
            @(negedge clk);
        end
        a_bus.mem_ack = 1'b0;
        a_fetch_req   = 1'b0;
        a_pc_load     = 1'b0;
        m_pc = next_pc;
        check_output("instr", a_instr, rdata);
        check_output("op", 32'(a_op), 32'(rdata[6:0]));
        check_output("rd", 32'(a_rd), 32'(rdata[11:7]));
        check_output("funct3", 32'(a_funct3), 32'(rdata[14:12]));
        check_output("rs1", 32'(a_rs1), 32'(rdata[19:15]));
        check_output("rs2", 32'(a_rs2), 32'(rdata[24:20]));
        check_output("funct7", 32'(a_funct7), 32'(rdata[31:25]));
        check_output("pc", a_pc, m_pc);
        check_output("old_pc", a_old_pc, addr);
        check_output("ir_valid", 32'(a_ir_valid), 32'd1);
        check_output("mem_req_done", 32'(a_bus.mem_req), 32'd0);
        check_output("busy_done", 32'(a_busy), 32'd0);
        @(negedge clk);
        check_output("ir_valid_drop", 32'(a_ir_valid), 32'd0);
        check_output("no_back_to_back", 32'(a_bus.mem_req), 32'd0);
        check_output("instr_held", a_instr, rdata);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] r;
        rst_n = 1'b0;
        a_fetch_req = 1'b0; a_pc_load = 1'b0; a_pc_target = '0;
        b_fetch_req = 1'b0; b_pc_load = 1'b0; b_pc_target = '0;
        a_bus.mem_ack = 1'b0; a_bus.mem_err = 1'b0; a_bus.mem_rdata = '0;
        b_bus.mem_ack = 1'b0; b_bus.mem_err = 1'b0; b_bus.mem_rdata = '0;
        m_pc = 32'h0;

        // Reset state
        @(negedge clk);
        check_output("rst_pc", a_pc, 32'h0);
        check_output("rst_op", 32'(a_op), 32'd0);
        check_output("rst_mem_req", 32'(a_bus.mem_req), 32'd0);
        check_output("rst_fault", 32'(a_fault), 32'd0);
        check_output("rst_busy", 32'(a_busy), 32'd0);
        check_output("rst_b_pc", b_pc, 32'h0000_1000);
        check_output("rst_b_old_pc", b_old_pc, 32'h0000_1000);
        rst_n = 1'b1;
        @(negedge clk);

        // Unit B: ack on the 4th waiting cycle is still accepted
        b_fetch_req = 1'b1;
        @(negedge clk);
        b_fetch_req = 1'b0;
        for (int w = 0; w < 4; w++) begin
            check_output("b_mem_req_wait", 32'(b_bus.mem_req), 32'd1);
            check_output("b_mem_addr", b_bus.mem_addr, 32'h0000_1000);
            b_bus.mem_ack   = (w == 3);
            b_bus.mem_rdata = 32'h0020_8133;
            @(negedge clk);
        end
        b_bus.mem_ack = 1'b0;
        check_output("b_fault_edge_ok", 32'(b_fault), 32'd0);
        check_output("b_ir_valid", 32'(b_ir_valid), 32'd1);
        check_output("b_op_rtype", 32'(b_op), 32'(OP_RTYPE));
        check_output("b_pc", b_pc, 32'h0000_1004);
        @(negedge clk);

        // Unit B: no ack within 4 waiting cycles ends in a sticky fault
        b_fetch_req = 1'b1;
        @(negedge clk);
        b_fetch_req = 1'b0;
        for (int w = 0; w < 4; w++) begin
            check_output("b_mem_req_to", 32'(b_bus.mem_req), 32'd1);
            check_output("b_fault_early", 32'(b_fault), 32'd0);
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            check_output("b_fault", 32'(b_fault), 32'd1);
            check_output("b_op_zero", 32'(b_op), 32'd0);
            check_output("b_mem_req_fault", 32'(b_bus.mem_req), 32'd0);
            b_fetch_req = 1'b1;
            b_bus.mem_ack = 1'b1;
            @(negedge clk);
        end
        b_fetch_req = 1'b0;
        b_bus.mem_ack = 1'b0;

        // Unit A: first fetch acknowledged in the first waiting cycle
        apply_stimulus(32'h00A0_0093, 0, 1'b0, 32'h0, 1'b0, 32'h0, 0);
        check_output("op_itype", 32'(a_op), 32'(OP_ITYPE));
        check_output("rd_is_1", 32'(a_rd), 32'd1);
        // Ack delayed 5 cycles, fetch_req pulses must have no effect
        apply_stimulus(32'h0000_006F, 5, 1'b0, 32'h0, 1'b0, 32'h0, 1);
        check_output("pc_after_delay", a_pc, 32'h8);
        // Redirect while waiting at pc=8
        apply_stimulus(32'h0000_0063, 2, 1'b0, 32'h0, 1'b1, 32'h40, 0);
        check_output("redirect_pc", a_pc, 32'h40);
        check_output("redirect_old_pc", a_old_pc, 32'h8);
        // Redirect together with fetch_req in idle
        apply_stimulus(32'h0000_0003, 1, 1'b1, 32'h100, 1'b0, 32'h0, 0);
        // PC wraps past the top of the address space
        apply_stimulus(32'h0000_0023, 0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 0);
        check_output("pc_wrap", a_pc, 32'h0);

        // Bus error with ack
        a_fetch_req = 1'b1;
        @(negedge clk);
        a_fetch_req = 1'b0;
        a_bus.mem_ack = 1'b1; a_bus.mem_err = 1'b1; a_bus.mem_rdata = 32'h1234_5673;
        @(negedge clk);
        a_bus.mem_ack = 1'b0; a_bus.mem_err = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check_output("err_fault", 32'(a_fault), 32'd1);
            check_output("err_op_zero", 32'(a_op), 32'd0);
            check_output("err_mem_req", 32'(a_bus.mem_req), 32'd0);
            check_output("err_ir_valid", 32'(a_ir_valid), 32'd0);
            a_fetch_req = 1'b1;
            @(negedge clk);
        end
        a_fetch_req = 1'b0;

        // Synchronous-looking reset clears both faults
        rst_n = 1'b0;
        #1;
        check_output("reset_a_fault", 32'(a_fault), 32'd0);
        check_output("reset_b_fault", 32'(b_fault), 32'd0);
        check_output("reset_b_pc", b_pc, 32'h0000_1000);
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = 32'h0;
        @(negedge clk);

        // Reset asserted in the middle of a request acts before the next edge
        a_fetch_req = 1'b1;
        @(negedge clk);
        a_fetch_req = 1'b0;
        check_output("mid_req_up", 32'(a_bus.mem_req), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_output("async_mem_req", 32'(a_bus.mem_req), 32'd0);
        check_output("async_busy", 32'(a_busy), 32'd0);
        check_output("async_pc", a_pc, 32'h0);
        check_output("async_mem_addr", a_bus.mem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        // A stray ack in idle after reset is ignored
        a_bus.mem_ack = 1'b1; a_bus.mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        a_bus.mem_ack = 1'b0;
        check_output("stray_ack_ir_valid", 32'(a_ir_valid), 32'd0);
        check_output("stray_ack_instr", a_instr, 32'h0);
        check_output("stray_ack_pc", a_pc, 32'h0);

        // Misaligned redirect faults without issuing a request
        a_pc_load = 1'b1; a_pc_target = 32'h0000_0202; a_fetch_req = 1'b1;
        @(negedge clk);
        a_pc_load = 1'b0; a_fetch_req = 1'b0;
        check_output("misalign_fault", 32'(a_fault), 32'd1);
        check_output("misalign_mem_req", 32'(a_bus.mem_req), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = 32'h0;
        @(negedge clk);

        // Randomized fetches against the transaction model
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                r = $urandom() & 32'hFFFF_FFFC;
                a_pc_load = 1'b1; a_pc_target = r;
                @(negedge clk);
                a_pc_load = 1'b0;
                m_pc = r;
                check_output("idle_redirect_pc", a_pc, m_pc);
            end
            r = $urandom() & 32'hFFFF_FFFC;
            apply_stimulus($urandom(), int'($urandom_range(0, 4)),
                           1'($urandom_range(0, 4) == 0), r, 1'b0, 32'h0, 3);
        end
        check_output("random_no_fault", 32'(a_fault), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
